fp32_add_seq: RTL and testbench



---
 rtl/fp32_add_seq.sv | 323 ++++++++++++++++++++++++++++++++
 tb/tb_fp32_add_seq.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/fp32_add_seq.sv
// rtl/fp32_add_seq.sv - multi-cycle IEEE-754 binary32 adder with valid/ready handshakes
//
// Purpose: computes input_01 + input_02 over a fixed six-state pipeline
//   (UNPACK, ALIGN, ADD, NORM, ROUND, DONE), one operation in flight.
//   Subnormal operands are flushed to signed zero. Rounding is round-to-nearest-even.
//   Optional macro FP_SUB_OP_EN adds the sub_op input (result = input_01 - input_02).
//   Parameter LAT_CHECK=1 enables an assertion that out_valid appears 5 cycles
//   after acceptance.
//
// Ports:
//   clk        in   1   rising-edge clock
//   rst_n      in   1   asynchronous active-low reset
//   in_valid   in   1   operands valid
//   in_ready   out  1   idle, operands accepted on in_valid && in_ready
//   input_01   in   32  operand A (binary32)
//   input_02   in   32  operand B (binary32)
//   sub_op     in   1   (FP_SUB_OP_EN only) subtract B instead of adding it
//   out_valid  out  1   result valid, held until out_ready
//   out_ready  in   1   downstream accepts result
//   result_add out  32  A+B (or A-B), binary32
//   flags      out  3   {invalid, overflow, underflow}, valid with out_valid
module fp32_add_seq #(
  parameter int LAT_CHECK = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] input_01,
  input  logic [31:0] input_02,
`ifdef FP_SUB_OP_EN
  input  logic        sub_op,
`endif
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result_add,
  output logic [2:0]  flags
);

  typedef enum logic [2:0] {
    S_IDLE, S_UNPACK, S_ALIGN, S_ADD, S_NORM, S_ROUND, S_DONE
  } state_e;

  state_e state_q, state_d;

  logic [31:0]       opa_q, opa_d, opb_q, opb_d;
  logic              spec_q, spec_d;
  logic [31:0]       spec_res_q, spec_res_d;
  logic [2:0]        spec_flg_q, spec_flg_d;
  logic              sa_q, sa_d, sb_q, sb_d;
  logic [7:0]        ea_q, ea_d, eb_q, eb_d;
  logic [23:0]       ma_q, ma_d, mb_q, mb_d;
  logic              sign_q, sign_d;
  logic              eff_sub_q, eff_sub_d;
  logic signed [9:0] exp_q, exp_d;
  logic [26:0]       mbig_q, mbig_d, msml_q, msml_d;
  logic [27:0]       sum_q, sum_d;
  logic [26:0]       norm_q, norm_d;
  logic              zero_q, zero_d;
  logic [31:0]       res_q, res_d;
  logic [2:0]        flg_q, flg_d;

  // Leading-zero count of a 27-bit value; 27 when the value is zero.
  function automatic logic [4:0] lzc27(input logic [26:0] v);
    lzc27 = 5'd27;
    for (int i = 0; i < 27; i++) begin
      if (v[i]) lzc27 = 5'(26 - i);
    end
  endfunction

  // ---------------- UNPACK decode of the latched operands ----------------
  logic ua_zero, ub_zero, ua_nan, ub_nan, ua_inf, ub_inf;
  assign ua_zero = (opa_q[30:23] == 8'd0);
  assign ub_zero = (opb_q[30:23] == 8'd0);
  assign ua_nan  = (opa_q[30:23] == 8'hFF) && (opa_q[22:0] != 23'd0);
  assign ub_nan  = (opb_q[30:23] == 8'hFF) && (opb_q[22:0] != 23'd0);
  assign ua_inf  = (opa_q[30:23] == 8'hFF) && (opa_q[22:0] == 23'd0);
  assign ub_inf  = (opb_q[30:23] == 8'hFF) && (opb_q[22:0] == 23'd0);

  // ---------------- ALIGN: order by magnitude, shift the smaller ----------------
  logic        swap, s_big, s_sml;
  logic [7:0]  e_big, e_sml, e_diff;
  logic [23:0] m_big24, m_sml24;
  logic [26:0] sml_ext, sml_shr, lost_mask, sml_aligned;
  logic        sml_sticky;

  assign swap    = {eb_q, mb_q} > {ea_q, ma_q};
  assign s_big   = swap ? sb_q : sa_q;
  assign s_sml   = swap ? sa_q : sb_q;
  assign e_big   = swap ? eb_q : ea_q;
  assign e_sml   = swap ? ea_q : eb_q;
  assign m_big24 = swap ? mb_q : ma_q;
  assign m_sml24 = swap ? ma_q : mb_q;
  assign e_diff  = e_big - e_sml;

  // Three extra low bits hold guard, round and sticky.
  assign sml_ext    = {m_sml24, 3'b000};
  assign sml_shr    = sml_ext >> e_diff;
  assign lost_mask  = ~({27{1'b1}} << e_diff);
  assign sml_sticky = |(sml_ext & lost_mask);
  // Beyond 26 positions every bit falls below sticky.
  assign sml_aligned = (e_diff >= 8'd27) ? {26'd0, |m_sml24}
                                         : {sml_shr[26:1], sml_shr[0] | sml_sticky};

  // ---------------- NORM helpers ----------------
  logic [4:0]  lz;
  logic [26:0] sum_shl;
  assign lz      = lzc27(sum_q[26:0]);
  assign sum_shl = sum_q[26:0] << lz;

  // ---------------- ROUND helpers ----------------
  logic              round_up;
  logic [24:0]       mant_r;
  logic signed [9:0] exp_r;
  logic [22:0]       frac_r;
  assign round_up = norm_q[2] & (norm_q[1] | norm_q[0] | norm_q[3]);
  assign mant_r   = {1'b0, norm_q[26:3]} + {24'd0, round_up};
  assign exp_r    = mant_r[24] ? (exp_q + 10'sd1) : exp_q;
  assign frac_r   = mant_r[24] ? mant_r[23:1] : mant_r[22:0];

  assign in_ready   = (state_q == S_IDLE);
  assign out_valid  = (state_q == S_DONE);
  assign result_add = res_q;
  assign flags      = flg_q;

  always_comb begin
    state_d    = state_q;
    opa_d      = opa_q;
    opb_d      = opb_q;
    spec_d     = spec_q;
    spec_res_d = spec_res_q;
    spec_flg_d = spec_flg_q;
    sa_d       = sa_q;
    sb_d       = sb_q;
    ea_d       = ea_q;
    eb_d       = eb_q;
    ma_d       = ma_q;
    mb_d       = mb_q;
    sign_d     = sign_q;
    eff_sub_d  = eff_sub_q;
    exp_d      = exp_q;
    mbig_d     = mbig_q;
    msml_d     = msml_q;
    sum_d      = sum_q;
    norm_d     = norm_q;
    zero_d     = zero_q;
    res_d      = res_q;
    flg_d      = flg_q;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          opa_d = input_01;
`ifdef FP_SUB_OP_EN
          opb_d = {input_02[31] ^ sub_op, input_02[30:0]};
`else
          opb_d = input_02;
`endif
          state_d = S_UNPACK;
        end
      end

      S_UNPACK: begin
        sa_d = opa_q[31];
        sb_d = opb_q[31];
        ea_d = opa_q[30:23];
        eb_d = opb_q[30:23];
        ma_d = ua_zero ? 24'd0 : {1'b1, opa_q[22:0]};
        mb_d = ub_zero ? 24'd0 : {1'b1, opb_q[22:0]};
        spec_d     = 1'b1;
        spec_flg_d = 3'b000;
        spec_res_d = 32'd0;
        if (ua_nan || ub_nan || (ua_inf && ub_inf && (opa_q[31] != opb_q[31]))) begin
          spec_res_d = 32'h7FC0_0000;
          spec_flg_d = 3'b100;
        end else if (ua_inf) begin
          spec_res_d = {opa_q[31], 8'hFF, 23'd0};
        end else if (ub_inf) begin
          spec_res_d = {opb_q[31], 8'hFF, 23'd0};
        end else if (ua_zero && ub_zero) begin
          // Only (-0)+(-0) keeps the negative sign.
          spec_res_d = {opa_q[31] & opb_q[31], 31'd0};
        end else begin
          spec_d = 1'b0;
        end
        state_d = S_ALIGN;
      end

      S_ALIGN: begin
        sign_d    = s_big;
        eff_sub_d = s_big ^ s_sml;
        exp_d     = $signed({2'b00, e_big});
        mbig_d    = {m_big24, 3'b000};
        msml_d    = sml_aligned;
        state_d   = S_ADD;
      end

      S_ADD: begin
        sum_d   = eff_sub_q ? ({1'b0, mbig_q} - {1'b0, msml_q})
                            : ({1'b0, mbig_q} + {1'b0, msml_q});
        state_d = S_NORM;
      end

      S_NORM: begin
        zero_d = (sum_q == 28'd0);
        if (sum_q[27]) begin
          norm_d = {sum_q[27:2], sum_q[1] | sum_q[0]};
          exp_d  = exp_q + 10'sd1;
        end else begin
          norm_d = sum_shl;
          exp_d  = exp_q - $signed({5'd0, lz});
        end
        state_d = S_ROUND;
      end

      S_ROUND: begin
        if (spec_q) begin
          res_d = spec_res_q;
          flg_d = spec_flg_q;
        end else if (zero_q) begin
          // Exact cancellation always yields +0.
          res_d = 32'd0;
          flg_d = 3'b000;
        end else if (exp_r >= 10'sd255) begin
          res_d = {sign_q, 8'hFF, 23'd0};
          flg_d = 3'b010;
        end else if (exp_r <= 10'sd0) begin
          res_d = {sign_q, 31'd0};
          flg_d = 3'b001;
        end else begin
          res_d = {sign_q, exp_r[7:0], frac_r};
          flg_d = 3'b000;
        end
        state_d = S_DONE;
      end

      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      opa_q      <= 32'd0;
      opb_q      <= 32'd0;
      spec_q     <= 1'b0;
      spec_res_q <= 32'd0;
      spec_flg_q <= 3'd0;
      sa_q       <= 1'b0;
      sb_q       <= 1'b0;
      ea_q       <= 8'd0;
      eb_q       <= 8'd0;
      ma_q       <= 24'd0;
      mb_q       <= 24'd0;
      sign_q     <= 1'b0;
      eff_sub_q  <= 1'b0;
      exp_q      <= 10'sd0;
      mbig_q     <= 27'd0;
      msml_q     <= 27'd0;
      sum_q      <= 28'd0;
      norm_q     <= 27'd0;
      zero_q     <= 1'b0;
      res_q      <= 32'd0;
      flg_q      <= 3'd0;
    end else begin
      state_q    <= state_d;
      opa_q      <= opa_d;
      opb_q      <= opb_d;
      spec_q     <= spec_d;
      spec_res_q <= spec_res_d;
      spec_flg_q <= spec_flg_d;
      sa_q       <= sa_d;
      sb_q       <= sb_d;
      ea_q       <= ea_d;
      eb_q       <= eb_d;
      ma_q       <= ma_d;
      mb_q       <= mb_d;
      sign_q     <= sign_d;
      eff_sub_q  <= eff_sub_d;
      exp_q      <= exp_d;
      mbig_q     <= mbig_d;
      msml_q     <= msml_d;
      sum_q      <= sum_d;
      norm_q     <= norm_d;
      zero_q     <= zero_d;
      res_q      <= res_d;
      flg_q      <= flg_d;
    end
  end

  generate
    if (LAT_CHECK != 0) begin : g_lat_check
      logic       busy_q;
      logic [2:0] cnt_q;

      // Counts edges since acceptance, saturating while the result waits.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          busy_q <= 1'b0;
          cnt_q  <= 3'd0;
        end else if (in_valid && in_ready) begin
          busy_q <= 1'b1;
          cnt_q  <= 3'd0;
        end else if (out_valid && out_ready) begin
          busy_q <= 1'b0;
        end else if (busy_q && (cnt_q != 3'd7)) begin
          cnt_q <= cnt_q + 3'd1;
        end
      end

      always_ff @(posedge clk) begin
        if (rst_n && busy_q) begin
          assert (out_valid == (cnt_q >= 3'd5));
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_fp32_add_seq.sv
// tb/tb_fp32_add_seq.sv - scoreboard bench for fp32_add_seq
module tb_fp32_add_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] input_01;
  logic [31:0] input_02;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result_add;
  logic [2:0]  flags;
`ifdef FP_SUB_OP_EN
  logic        sub_op;
`endif

  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  logic [34:0] exp_q[$];
  int          acc_q[$];
  logic        prev_ov = 1'b0;

  fp32_add_seq dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .input_01   (input_01),
    .input_02   (input_02),
`ifdef FP_SUB_OP_EN
    .sub_op     (sub_op),
`endif
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result_add (result_add),
    .flags      (flags)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    end
  endtask

  // Scoreboard side: latency on each new result, value check on each handshake.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && !prev_ov) begin
        if (acc_q.size() > 0) chk("latency", 64'(cyc - acc_q[0]), 64'd5);
        else                  chk("unexpected_out_valid", {63'd0, out_valid}, 64'd0);
      end
      if (out_valid && out_ready && (exp_q.size() > 0)) begin
        chk("result_add", {32'd0, result_add}, {32'd0, exp_q[0][34:3]});
        chk("flags", {61'd0, flags}, {61'd0, exp_q[0][2:0]});
        void'(exp_q.pop_front());
        if (acc_q.size() > 0) void'(acc_q.pop_front());
      end
    end
    prev_ov <= out_valid;
  end

  task automatic drive_ops(input logic [31:0] a, input logic [31:0] b, input logic sub,
                           input logic [31:0] er, input logic [2:0] ef);
    int n;
    @(posedge clk); #1;
    input_01 = a;
    input_02 = b;
`ifdef FP_SUB_OP_EN
    sub_op = sub;
`else
    if (sub) chk("sub_op_unavailable", 64'd1, 64'd0);
`endif
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) chk("in_ready_timeout", {63'd0, in_ready}, 64'd1);
    exp_q.push_back({er, ef});
    acc_q.push_back(cyc + 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
`ifdef FP_SUB_OP_EN
    sub_op = 1'b0;
`endif
    chk("in_ready_busy", {63'd0, in_ready}, 64'd0);
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] er, input logic [2:0] ef);
    drive_ops(a, b, 1'b0, er, ef);
  endtask

  task automatic collect(input int hold);
    int          n;
    logic [31:0] r0;
    logic [2:0]  f0;
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!out_valid) begin
      chk("out_valid_timeout", {63'd0, out_valid}, 64'd1);
      return;
    end
    r0 = result_add;
    f0 = flags;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("hold_out_valid", {63'd0, out_valid}, 64'd1);
      chk("hold_result", {32'd0, result_add}, {32'd0, r0});
      chk("hold_flags", {61'd0, flags}, {61'd0, f0});
      chk("hold_in_ready", {63'd0, in_ready}, 64'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("in_ready_after_handshake", {63'd0, in_ready}, 64'd1);
    chk("out_valid_after_handshake", {63'd0, out_valid}, 64'd0);
  endtask

  task automatic run(input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] er, input logic [2:0] ef);
    send(a, b, er, ef);
    collect(0);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    input_01  = 32'd0;
    input_02  = 32'd0;
`ifdef FP_SUB_OP_EN
    sub_op    = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    chk("reset_in_ready", {63'd0, in_ready}, 64'd1);
    chk("reset_out_valid", {63'd0, out_valid}, 64'd0);
    chk("reset_result", {32'd0, result_add}, 64'd0);
    chk("reset_flags", {61'd0, flags}, 64'd0);
    rst_n = 1'b1;

    // Basic add with the result held back by out_ready.
    send(32'hBFC0_0000, 32'h4040_0000, 32'h3FC0_0000, 3'b000);
    collect(3);

`ifdef FP_SUB_OP_EN
    drive_ops(32'hBFC0_0000, 32'h4040_0000, 1'b1, 32'hC090_0000, 3'b000);
    collect(0);
`endif
    run(32'h3F80_0000, 32'hBF80_0000, 32'h0000_0000, 3'b000);
    run(32'h3F80_0000, 32'h3380_0000, 32'h3F80_0000, 3'b000);
    run(32'h3F80_0000, 32'h33C0_0000, 32'h3F80_0001, 3'b000);
    run(32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000, 3'b000);
    run(32'h7F80_0000, 32'hFF80_0000, 32'h7FC0_0000, 3'b100);
    run(32'h7F7F_FFFF, 32'h7F7F_FFFF, 32'h7F80_0000, 3'b010);
    run(32'h0040_0000, 32'h0000_0000, 32'h0000_0000, 3'b000);
    run(32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 3'b000);
    run(32'h7F80_0000, 32'h3F80_0000, 32'h7F80_0000, 3'b000);
    run(32'h7FC0_0001, 32'h3F80_0000, 32'h7FC0_0000, 3'b100);
    run(32'h0080_0000, 32'h8080_0001, 32'h8000_0000, 3'b001);

    // Reset two cycles into an operation aborts it.
    send(32'h4040_0000, 32'h4040_0000, 32'h40C0_0000, 3'b000);
    @(posedge clk); #1;
    rst_n = 1'b0;
    exp_q.delete();
    acc_q.delete();
    repeat (3) begin
      @(posedge clk); #1;
      chk("abort_out_valid", {63'd0, out_valid}, 64'd0);
    end
    rst_n = 1'b1;
    chk("abort_in_ready", {63'd0, in_ready}, 64'd1);
    repeat (8) begin
      @(posedge clk); #1;
      chk("abort_no_result", {63'd0, out_valid}, 64'd0);
    end
    run(32'h4000_0000, 32'h4000_0000, 32'h4080_0000, 3'b000);

    // in_valid while busy is ignored.
    send(32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000, 3'b000);
    @(posedge clk); #1;
    input_01 = 32'h1234_5678;
    input_02 = 32'h1234_5678;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    collect(1);
    repeat (10) begin
      @(posedge clk); #1;
      chk("no_extra_out_valid", {63'd0, out_valid}, 64'd0);
    end

    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
